// File: rtl/nw_job_scheduler.sv
// nw_job_scheduler
// Accepts string-pair jobs from two requesters (round-robin on ties), loads
// the winner's strings into a single Needleman-Wunsch grid, holds the grid
// in reset for a clear window, then runs it until grid_valid or a timeout.
// The outcome is returned on a valid/ready response port.
//
// Ports:
//   clk, reset              clock, async active-high reset
//   req0_*, req1_*          job request ports (valid/ready + two strings)
//   grid_reset              reset to the grid (high except while running)
//   grid_s1, grid_s2        strings driven to the grid
//   grid_score, grid_valid  grid result
//   rsp_valid, rsp_ready    response handshake
//   rsp_id, rsp_score       owning requester, captured score (0 on timeout)
//   rsp_timeout             job abandoned by timeout
//   busy                    a job is in flight or its response is pending
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | grid held in reset, waiting to grant a requester
// CLEAR | new strings applied, grid held in reset for CLEAR_CYCLES cycles
// RUN   | grid released, waiting for grid_valid or the timeout
// DONE  | response presented until rsp_ready
module nw_job_scheduler #(
    parameter int LENGTH       = 10,
    parameter int CWIDTH       = 2,
    parameter int SWIDTH       = 16,
    parameter int CLEAR_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int TWIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [LENGTH*CWIDTH-1:0]   req0_s1,
    input  logic [LENGTH*CWIDTH-1:0]   req0_s2,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [LENGTH*CWIDTH-1:0]   req1_s1,
    input  logic [LENGTH*CWIDTH-1:0]   req1_s2,
    output logic                       grid_reset,
    output logic [LENGTH*CWIDTH-1:0]   grid_s1,
    output logic [LENGTH*CWIDTH-1:0]   grid_s2,
    input  logic signed [SWIDTH-1:0]   grid_score,
    input  logic                       grid_valid,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic signed [SWIDTH-1:0]   rsp_score,
    output logic                       rsp_timeout,
    output logic                       busy
);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    // Down-counter reload values: the phase ends on the cycle the counter
    // reads zero, so CLEAR lasts CLEAR_CYCLES cycles and RUN lasts at most
    // TIMEOUT cycles.
    localparam logic [TWIDTH-1:0] CLR_LOAD = TWIDTH'(CLEAR_CYCLES - 1);
    localparam logic [TWIDTH-1:0] RUN_LOAD = TWIDTH'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [TWIDTH-1:0] cnt;
    logic              cnt_zero;
    logic              last_grant;
    logic              grant_any;
    logic              grant_id;
    logic              accept;

    always_comb begin
        grant_any  = req0_valid | req1_valid;
        // On a tie the requester that did not win last time goes next.
        grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = (state == IDLE) & grant_any & ~grant_id;
        req1_ready = (state == IDLE) & grant_any & grant_id;
        accept     = req0_ready | req1_ready;
        cnt_zero   = (cnt == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grid_reset = 1'b1;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_zero) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                grid_reset = 1'b0;
                if (grid_valid || cnt_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            last_grant  <= 1'b1;
            grid_s1     <= '0;
            grid_s2     <= '0;
            rsp_id      <= 1'b0;
            rsp_score   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grid_s1    <= grant_id ? req1_s1 : req0_s1;
                        grid_s2    <= grant_id ? req1_s2 : req0_s2;
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        cnt        <= CLR_LOAD;
                    end
                end
                CLEAR: begin
                    cnt <= cnt_zero ? RUN_LOAD : cnt - 1'b1;
                end
                RUN: begin
                    // A result arriving in the final cycle beats the timeout.
                    if (grid_valid) begin
                        rsp_score   <= grid_score;
                        rsp_timeout <= 1'b0;
                    end else if (cnt_zero) begin
                        rsp_score   <= '0;
                        rsp_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
